// File: rtl/uidbufr_interconnect.sv
// Four-to-one FDMA read-channel arbiter; one channel owns the port for a whole burst.
// Optional UIDBUFR_IC_ROUND_ROBIN_EN selects round-robin instead of fixed priority (ch1 highest).
module uidbufr_interconnect #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 23
) (
   input  logic                      ui_clk,
   input  logic                      ui_rst,
   input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_1,
   input  logic                      fdma_rareq_1,
   input  logic [15:0]               fdma_rsize_1,
   output logic                      fdma_rbusy_1,
   output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_1,
   output logic                      fdma_rvalid_1,
   input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_2,
   input  logic                      fdma_rareq_2,
   input  logic [15:0]               fdma_rsize_2,
   output logic                      fdma_rbusy_2,
   output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_2,
   output logic                      fdma_rvalid_2,
   input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_3,
   input  logic                      fdma_rareq_3,
   input  logic [15:0]               fdma_rsize_3,
   output logic                      fdma_rbusy_3,
   output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_3,
   output logic                      fdma_rvalid_3,
   input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_4,
   input  logic                      fdma_rareq_4,
   input  logic [15:0]               fdma_rsize_4,
   output logic                      fdma_rbusy_4,
   output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_4,
   output logic                      fdma_rvalid_4,
   output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
   output logic                      fdma_rareq,
   output logic [15:0]               fdma_rsize,
   input  logic                      fdma_rbusy,
   input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
   input  logic                      fdma_rvalid,
   output logic [3:0]                grant,
   output logic                      err_len
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                win_q, win_d;
   logic [3:0]                grant_q, grant_d;
   logic                      rareq_q, rareq_d;
   logic [AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [15:0]               rsize_q, rsize_d;
   logic [15:0]               cnt_q, cnt_d;
   logic                      err_q, err_d;

   logic [3:0]                req;
   logic [AXI_ADDR_WIDTH-1:0] addr_a [4];
   logic [15:0]               size_a [4];
   logic [1:0]                win_idx;
   logic                      found;

   assign req       = {fdma_rareq_4, fdma_rareq_3, fdma_rareq_2, fdma_rareq_1};
   assign addr_a[0] = fdma_raddr_1;
   assign addr_a[1] = fdma_raddr_2;
   assign addr_a[2] = fdma_raddr_3;
   assign addr_a[3] = fdma_raddr_4;
   assign size_a[0] = fdma_rsize_1;
   assign size_a[1] = fdma_rsize_2;
   assign size_a[2] = fdma_rsize_3;
   assign size_a[3] = fdma_rsize_4;

`ifdef UIDBUFR_IC_ROUND_ROBIN_EN
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] idx;

   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            found   = 1'b1;
            win_idx = idx;
         end
      end
   end
`else
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!found && req[i]) begin
            found   = 1'b1;
            win_idx = 2'(i);
         end
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      grant_d = grant_q;
      rareq_d = rareq_q;
      raddr_d = raddr_q;
      rsize_d = rsize_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`ifdef UIDBUFR_IC_ROUND_ROBIN_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d   = win_idx;
               grant_d = 4'b0001 << win_idx;
               raddr_d = addr_a[win_idx];
               rsize_d = size_a[win_idx];
               rareq_d = 1'b1;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // beats returned alongside the busy handshake still belong to the owner
            if (fdma_rvalid) cnt_d = cnt_q + 16'd1;
            if (fdma_rbusy) begin
               rareq_d = 1'b0;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (fdma_rvalid) cnt_d = cnt_q + 16'd1;
            if (!fdma_rbusy) state_d = S_REL;
         end
         S_REL: begin
            if (cnt_q != rsize_q) err_d = 1'b1;
            grant_d = '0;
`ifdef UIDBUFR_IC_ROUND_ROBIN_EN
            ptr_d   = win_q + 2'd1;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         state_q <= S_IDLE;
         win_q   <= '0;
         grant_q <= '0;
         rareq_q <= 1'b0;
         raddr_q <= '0;
         rsize_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef UIDBUFR_IC_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         rareq_q <= rareq_d;
         raddr_q <= raddr_d;
         rsize_q <= rsize_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef UIDBUFR_IC_ROUND_ROBIN_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign fdma_raddr    = raddr_q;
   assign fdma_rareq    = rareq_q;
   assign fdma_rsize    = rsize_q;
   assign grant         = grant_q;
   assign err_len       = err_q;

   assign fdma_rbusy_1  = grant_q[0] & fdma_rbusy;
   assign fdma_rbusy_2  = grant_q[1] & fdma_rbusy;
   assign fdma_rbusy_3  = grant_q[2] & fdma_rbusy;
   assign fdma_rbusy_4  = grant_q[3] & fdma_rbusy;
   assign fdma_rvalid_1 = grant_q[0] & fdma_rvalid;
   assign fdma_rvalid_2 = grant_q[1] & fdma_rvalid;
   assign fdma_rvalid_3 = grant_q[2] & fdma_rvalid;
   assign fdma_rvalid_4 = grant_q[3] & fdma_rvalid;
   assign fdma_rdata_1  = fdma_rdata;
   assign fdma_rdata_2  = fdma_rdata;
   assign fdma_rdata_3  = fdma_rdata;
   assign fdma_rdata_4  = fdma_rdata;

endmodule

// File: tb/tb_uidbufr_interconnect.sv
// Scoreboard bench for uidbufr_interconnect: expected grants are queued when requests are
// driven and popped when the controller model sees fdma_rareq.
module tb_uidbufr_interconnect;

   localparam int DW = 32;
   localparam int AW = 23;

   typedef struct packed {
      logic [3:0]    g;
      logic [AW-1:0] a;
      logic [15:0]   s;
   } exp_t;

   logic          clk, rst;
   logic [3:0]    rq;
   logic [AW-1:0] ad [4];
   logic [15:0]   sz [4];
   logic          rbusy, rvalid;
   logic [DW-1:0] rdata;
   logic          b1, b2, b3, b4, v1, v2, v3, v4;
   logic [DW-1:0] d1, d2, d3, d4;
   logic [AW-1:0] fdma_raddr;
   logic          fdma_rareq;
   logic [15:0]   fdma_rsize;
   logic [3:0]    grant;
   logic          err_len;
   logic [3:0]    bo, vo;

   exp_t          sb [$];
   int unsigned   total, passed;
   int unsigned   cyc, fall_cyc;
   bit            have_fall, hold_req, drop_all;
   int unsigned   vcnt [4];
   int unsigned   exp_cnt [4];

   assign bo = {b4, b3, b2, b1};
   assign vo = {v4, v3, v2, v1};

   uidbufr_interconnect #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
      .ui_clk(clk), .ui_rst(rst),
      .fdma_raddr_1(ad[0]), .fdma_rareq_1(rq[0]), .fdma_rsize_1(sz[0]),
      .fdma_rbusy_1(b1), .fdma_rdata_1(d1), .fdma_rvalid_1(v1),
      .fdma_raddr_2(ad[1]), .fdma_rareq_2(rq[1]), .fdma_rsize_2(sz[1]),
      .fdma_rbusy_2(b2), .fdma_rdata_2(d2), .fdma_rvalid_2(v2),
      .fdma_raddr_3(ad[2]), .fdma_rareq_3(rq[2]), .fdma_rsize_3(sz[2]),
      .fdma_rbusy_3(b3), .fdma_rdata_3(d3), .fdma_rvalid_3(v3),
      .fdma_raddr_4(ad[3]), .fdma_rareq_4(rq[3]), .fdma_rsize_4(sz[3]),
      .fdma_rbusy_4(b4), .fdma_rdata_4(d4), .fdma_rvalid_4(v4),
      .fdma_raddr(fdma_raddr), .fdma_rareq(fdma_rareq), .fdma_rsize(fdma_rsize),
      .fdma_rbusy(rbusy), .fdma_rdata(rdata), .fdma_rvalid(rvalid),
      .grant(grant), .err_len(err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (v1) vcnt[0] <= vcnt[0] + 1;
      if (v2) vcnt[1] <= vcnt[1] + 1;
      if (v3) vcnt[2] <= vcnt[2] + 1;
      if (v4) vcnt[3] <= vcnt[3] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_req(input int ch, input logic [AW-1:0] a, input logic [15:0] s);
      ad[ch] = a;
      sz[ch] = s;
      rq[ch] = 1'b1;
   endtask

   task automatic expect_burst(input int ch, input int beats);
      exp_t e;
      e.g = 4'b0001 << ch;
      e.a = ad[ch];
      e.s = sz[ch];
      sb.push_back(e);
      exp_cnt[ch] += beats;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      rq     = '0;
      rbusy  = 1'b0;
      rvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      have_fall = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_counts(input string tag);
      for (int i = 0; i < 4; i++) chk(tag, vcnt[i], exp_cnt[i]);
   endtask

   // Controller model: one burst per call; abort_at>0 leaves rbusy high after that many beats.
   task automatic serve(input int beats, input int pre_delay, input bit drop_early, input int abort_at);
      exp_t e;
      int   w;
      w = 0;
      while (!fdma_rareq && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!fdma_rareq) begin
         chk("rareq_timeout", 0, 1);
         return;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      chk("grant", grant, e.g);
      chk("raddr", fdma_raddr, e.a);
      chk("rsize", fdma_rsize, e.s);
      if (have_fall) chk("arb_gap", 32'((cyc - fall_cyc) >= 2), 1);
      if (drop_early) rq = rq & ~e.g;
      repeat (pre_delay) @(negedge clk);
      if (pre_delay > 0) begin
         chk("req_hold", fdma_rareq, 1);
         chk("grant_hold", grant, e.g);
      end
      rbusy = 1'b1;
      #1 chk("busy_route", bo, e.g);
      @(negedge clk);
      chk("rareq_drop", fdma_rareq, 0);
      if (!hold_req) rq = rq & ~e.g;
      for (int i = 0; i < beats; i++) begin
         rvalid = 1'b1;
         rdata  = $urandom;
         #1;
         if (i == 0) begin
            chk("vld_route", vo, e.g);
            chk("rdata_bcast", d3, rdata);
         end
         @(negedge clk);
         if (abort_at > 0 && i + 1 == abort_at) begin
            rvalid = 1'b0;
            return;
         end
      end
      rvalid    = 1'b0;
      rbusy     = 1'b0;
      if (drop_all) rq = '0;
      fall_cyc  = cyc;
      have_fall = 1'b1;
      @(negedge clk);
      chk("grant_rel", grant, e.g);
      @(negedge clk);
      chk("grant_clr", grant, 0);
   endtask

   initial begin
      total = 0; passed = 0; cyc = 0; fall_cyc = 0;
      have_fall = 0; hold_req = 0; drop_all = 0;
      rdata = '0;
      for (int i = 0; i < 4; i++) begin
         ad[i] = '0; sz[i] = '0; vcnt[i] = 0; exp_cnt[i] = 0;
      end
      do_reset();

      // reset state
      chk("rst_grant", grant, 0);
      chk("rst_rareq", fdma_rareq, 0);
      chk("rst_raddr", fdma_raddr, 0);
      chk("rst_rsize", fdma_rsize, 0);
      chk("rst_err", err_len, 0);
      chk("rst_busy_n", bo, 0);
      chk("rst_vld_n", vo, 0);

      // channel 2 alone, 256 beats
      set_req(1, 23'h001000, 16'd256);
      expect_burst(1, 256);
      serve(256, 0, 0, 0);
      check_counts("ch2_beats");
      chk("ch2_err", err_len, 0);

      // all four requesting continuously
      do_reset();
      hold_req = 1;
      set_req(0, 23'h010000, 16'd4);
      set_req(1, 23'h020000, 16'd4);
      set_req(2, 23'h030000, 16'd4);
      set_req(3, 23'h040000, 16'd4);
      for (int k = 0; k < 5; k++) begin
`ifdef UIDBUFR_IC_ROUND_ROBIN_EN
         expect_burst(k % 4, 4);
`else
         expect_burst(0, 4);
`endif
      end
      for (int k = 0; k < 5; k++) begin
         drop_all = (k == 4);
         serve(4, 0, 0, 0);
      end
      hold_req = 0;
      drop_all = 0;
      check_counts("cont_beats");
      chk("cont_err", err_len, 0);

      // short burst sets sticky err_len
      do_reset();
      set_req(3, 23'h050000, 16'd256);
      expect_burst(3, 255);
      serve(255, 0, 0, 0);
      chk("err_set", err_len, 1);
      set_req(0, 23'h060000, 16'd8);
      expect_burst(0, 8);
      serve(8, 0, 0, 0);
      chk("err_sticky", err_len, 1);
      check_counts("err_beats");
      do_reset();
      chk("err_clr", err_len, 0);

      // reset during channel 3 transfer
      set_req(2, 23'h070000, 16'd16);
      expect_burst(2, 5);
      serve(16, 0, 0, 5);
      rst = 1'b1;
      #1;
      chk("arst_grant", grant, 0);
      chk("arst_rareq", fdma_rareq, 0);
      chk("arst_busy_n", bo, 0);
      rbusy = 1'b0;
      set_req(0, 23'h080000, 16'd2);
      set_req(2, 23'h070000, 16'd16);
      @(negedge clk);
      rst = 1'b0;
      have_fall = 0;
      expect_burst(0, 2);
      expect_burst(2, 16);
      serve(2, 0, 0, 0);
      serve(16, 0, 0, 0);
      check_counts("arst_beats");

      // channel 1 drops request while in REQ
      set_req(0, 23'h0abcde, 16'd3);
      expect_burst(0, 3);
      serve(3, 3, 1, 0);
      chk("drop_err", err_len, 0);
      check_counts("drop_beats");
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uidbufr_interconnect.md
# uidbufr_interconnect

Four-to-one FDMA read-channel arbiter: merges four independent `uidbuf` read requesters onto the single FDMA read port of the SDRAM controller. It is the read-direction counterpart of `uidbufw_interconnect`. It serialises whole bursts: one channel owns the port from request through the end of `fdma_rbusy`. Returned data is routed only to the owning channel.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 32: FDMA data width.
- `AXI_ADDR_WIDTH`, 23: FDMA address width.

Ports (n = 1..4, one set per channel):
- `ui_clk`  in  1  FDMA clock. Single clock domain.
- `ui_rst`  in  1  Reset, asynchronous, active-high.
- `fdma_raddr_n`  in  AXI_ADDR_WIDTH  Channel burst address.
- `fdma_rareq_n`  in  1  Channel request. Level; held until the channel sees `fdma_rbusy_n`.
- `fdma_rsize_n`  in  16  Channel burst length in beats.
- `fdma_rbusy_n`  out  1  `grant[n] & fdma_rbusy`.
- `fdma_rdata_n`  out  AXI_DATA_WIDTH  `fdma_rdata`, broadcast to all channels.
- `fdma_rvalid_n`  out  1  `grant[n] & fdma_rvalid`.
- `fdma_raddr`  out  AXI_ADDR_WIDTH  Registered address of the granted channel.
- `fdma_rareq`  out  1  Registered request to the controller.
- `fdma_rsize`  out  16  Registered size of the granted channel.
- `fdma_rbusy`  in  1  Controller busy.
- `fdma_rdata`  in  AXI_DATA_WIDTH  Controller read data.
- `fdma_rvalid`  in  1  Controller data-valid.
- `grant`  out  4  One-hot owner; all zeros when idle.
- `err_len`  out  1  Sticky flag: a burst's beat count differed from its `fdma_rsize`.

## Operation
FSM states: IDLE, REQ, XFER, REL.
- IDLE:
  - If any `fdma_rareq_n` is high, pick a winner by the priority rule.
  - Register the winner's addr/size into `fdma_raddr`/`fdma_rsize`, set `grant`, set `fdma_rareq`=1, clear the beat counter, go to REQ.
- REQ: hold `fdma_rareq`=1 until `fdma_rbusy`=1 is sampled. On that cycle drop `fdma_rareq` and go to XFER.
- XFER: on each `fdma_rvalid`, increment the 16-bit beat counter. When `fdma_rbusy`=0 is sampled, go to REL.
- REL:
  - If beat count != `fdma_rsize`, set `err_len`=1 (sticky).
  - Clear `grant`, update the priority pointer, return to IDLE.
- Addr/size are captured once in IDLE. Later changes on channel inputs are ignored for the current burst.
- Non-granted channels see rbusy=0 and rvalid=0. Their requests stay pending, are not lost, and are not forwarded.
- A channel that drops its request while in REQ does not abort the burst; the burst completes normally.
- `fdma_rvalid` arriving in IDLE or REL is ignored and not counted.
- `err_len` is cleared only by `ui_rst`.

## Timing
- Reset values:
  - `fdma_rareq`=0, `fdma_raddr`=0, `fdma_rsize`=0.
  - `grant`=0, all `fdma_rbusy_n`/`fdma_rvalid_n`=0.
  - `err_len`=0, FSM=IDLE, priority pointer = channel 1.
- Asserting reset mid-burst clears everything immediately (asynchronous). In-flight data is discarded.
- Request latency: `fdma_rareq_n` sampled high in IDLE at edge k gives `fdma_rareq`=1 and `grant` valid after edge k.
- Data path: rdata/rvalid/rbusy routing is combinational, zero latency from controller inputs.
- `fdma_rareq` falls on the edge after `fdma_rbusy` is first sampled high.
- Arbitration gap: REL takes one cycle and IDLE takes at least one cycle. The next grant is issued no earlier than 2 cycles after `fdma_rbusy` falls.
- Simultaneous requests: resolved in a single IDLE cycle. Exactly one grant bit is set.

## Configuration
- `UIDBUFR_IC_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration.
  - The pointer moves to the channel after the last winner in REL.
  - Search order is pointer, pointer+1, … with wrap-around 4→1.
- Not defined:
  - Fixed priority, channel 1 highest and channel 4 lowest.
  - The pointer is unused, so a continuously requesting channel 1 starves channels 2–4.

## Test plan
- Channel 2 alone requests addr 0x001000, size 256; controller asserts rbusy and returns 256 rvalid beats -> `fdma_raddr`=0x001000, `fdma_rsize`=256, `grant`=4'b0010, `fdma_rvalid_2` pulses 256 times, other channels see 0, `err_len`=0.
- All four channels request continuously (ROUND_ROBIN_EN defined) -> grant order 1,2,3,4,1; next `fdma_rareq` rises ≥2 cycles after each rbusy fall.
- Same stimulus with the macro undefined -> channel 1 is granted every burst; channels 2–4 are never granted.
- Size 256 but controller returns 255 beats -> `err_len`=1 after REL and stays 1 through later correct bursts until `ui_rst`.
- Reset asserted during XFER of channel 3 -> `grant`=0, `fdma_rareq`=0 immediately; after release, channel 1 request is served first.
- Channel 1 drops rareq while in REQ, before rbusy -> burst still completes; `grant` clears only after rbusy falls.
